// File: rtl/ps_readout_fifo.sv
// PL-to-PS readout FIFO: PL pushes words, software pops one word per request toggle
// through a show-ahead rdata register, with clear toggle and sticky error status.
module ps_readout_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  input  logic [31:0]   ctl,
  output logic [DW-1:0] rdata,
  output logic [31:0]   status
);

  localparam int unsigned Depth  = 2 ** AW;
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StAck,
    StClear
  } state_e;

  state_e state_q, state_d;

  logic [DW-1:0] mem [Depth];

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          full_q, full_d;
  logic [7:0]    drop_q, drop_d;
  logic [1:0]    ctl_q;
  logic          req_seen_q, req_seen_d;
  logic          clr_seen_q, clr_seen_d;

  logic          in_clear;
  logic          pop;
  logic          accept;
  logic          drop;
  logic [AW:0]   fill;
  logic [AW+1:0] count;

  logic          unused_ctl;
  assign unused_ctl = ^ctl[31:2];

  assign in_clear = (state_q == StClear);
  assign pop      = (state_q == StLoad);
  // A refill in the same cycle frees a slot, so a write at full is still taken.
  assign accept   = wr_en && !in_clear && (!full_q || pop);
  assign drop     = wr_en && !in_clear && !accept;

  assign fill  = wr_ptr_q - rd_ptr_q;
  assign count = {1'b0, fill} + {{(AW + 1){1'b0}}, valid_q};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rdata_d    = rdata_q;
    valid_d    = valid_q;
    ack_d      = ack_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    drop_d     = drop_q;
    req_seen_d = req_seen_q;
    clr_seen_d = clr_seen_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hff) begin
        drop_d = drop_q + 8'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (ctl_q[1] != clr_seen_q) begin
          state_d = StClear;
        end else if (ctl_q[0] != req_seen_q) begin
          state_d = StAck;
        end else if (!valid_q && (wr_ptr_d != rd_ptr_q)) begin
          // Looking at the next write pointer lets a fresh push load one cycle sooner.
          state_d = StLoad;
        end
      end
      StLoad: begin
        rdata_d  = mem[rd_ptr_q[AW-1:0]];
        rd_ptr_d = rd_ptr_q + PtrOne;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      StAck: begin
        req_seen_d = ctl_q[0];
        if (valid_q) begin
          valid_d = 1'b0;
        end else begin
          udf_d = 1'b1;
        end
        ack_d   = ctl_q[0];
        state_d = StIdle;
      end
      StClear: begin
        wr_ptr_d   = '0;
        rd_ptr_d   = '0;
        valid_d    = 1'b0;
        rdata_d    = '0;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;
        drop_d     = 8'd0;
        clr_seen_d = ctl_q[1];
        // A request still pending is answered by the next ACK, not here.
        ack_d      = req_seen_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      full_q     <= 1'b0;
      drop_q     <= 8'd0;
      ctl_q      <= 2'b00;
      req_seen_q <= 1'b0;
      clr_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      full_q     <= full_d;
      drop_q     <= drop_d;
      ctl_q      <= ctl[1:0];
      req_seen_q <= req_seen_d;
      clr_seen_q <= clr_seen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = ack_q;
    status[1]     = valid_q;
    status[2]     = ovf_q;
    status[3]     = udf_q;
    status[4]     = full_q;
    status[12:8]  = 5'(count);
    status[23:16] = drop_q;
  end

  assign full  = full_q;
  assign rdata = rdata_q;

endmodule
